// File: rtl/fifo_valid_ready_reader_pkg.sv
// Package: fifo_valid_ready_reader_pkg
//
// Purpose: parameter limits for the FIFO valid/ready reader. Pointer and level
// widths are derived locally inside the reader from its own BUFFER_DEPTH, so
// only the legal parameter range lives here.
//
// Contents:
//   MAX_READ_LATENCY  largest supported FIFO read latency (0 or 1 are legal)
//   MIN_BUFFER_DEPTH  smallest legal internal buffer depth
package fifo_valid_ready_reader_pkg;

  localparam int MAX_READ_LATENCY = 1;
  localparam int MIN_BUFFER_DEPTH = 2;

endpackage : fifo_valid_ready_reader_pkg

// File: rtl/fifo_valid_ready_reader.sv
// Module: fifo_valid_ready_reader
//
// Purpose: drains a read-enable style FIFO into a small internal buffer and
// presents the buffered data as a valid/ready stream. Reads are issued purely
// on buffer credit (level plus any read still in flight), so read_ready never
// reaches fifo_read_enable combinationally. FIFOs with read latency 0
// (first-word fall-through) and 1 (registered read data) are supported.
//
// Ports:
//   clock             in   1      rising-edge clock for all state
//   reset             in   1      asynchronous active-high reset
//   fifo_read_enable  out  1      pops one FIFO entry this cycle
//   fifo_read_data    in   WIDTH  FIFO data (same cycle for LAT=0, next for LAT=1)
//   fifo_empty        in   1      FIFO empty flag
//   read_valid        out  1      read_data holds a valid entry
//   read_data         out  WIDTH  head-of-buffer data, taken from storage flops
//   read_ready        in   1      consumer accepts when read_valid && read_ready
//   level             out  clog2(BUFFER_DEPTH+1)  entries held in the buffer
module fifo_valid_ready_reader
  import fifo_valid_ready_reader_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int READ_LATENCY = 0,
  parameter int BUFFER_DEPTH = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  output logic                              fifo_read_enable,
  input  logic [WIDTH-1:0]                  fifo_read_data,
  input  logic                              fifo_empty,
  output logic                              read_valid,
  output logic [WIDTH-1:0]                  read_data,
  input  logic                              read_ready,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0] level
);

  localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int LVL_W = $clog2(BUFFER_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUFFER_DEPTH - 1);
  localparam logic [LVL_W:0]   DEPTH_EXT = (LVL_W + 1)'(BUFFER_DEPTH);

  // Reject unsupported configurations at elaboration.
  if ((READ_LATENCY < 0) || (READ_LATENCY > MAX_READ_LATENCY) ||
      (BUFFER_DEPTH < MIN_BUFFER_DEPTH)) begin : g_param_check
    $error("fifo_valid_ready_reader: READ_LATENCY must be 0 or 1 and BUFFER_DEPTH >= 2");
  end

  logic [WIDTH-1:0] storage [BUFFER_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_r;
  logic [LVL_W-1:0] level_next;
  logic             valid_r;
  logic             inflight_r;
  logic             inflight_s;
  logic             push_s;
  logic             pop_s;
  logic [LVL_W:0]   credit_sum;

  // Pointers wrap by explicit compare so any depth works, not only powers of 2.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // A latency-1 read issued last cycle still owns a buffer slot until it lands.
  assign inflight_s = (READ_LATENCY == 1) ? inflight_r : 1'b0;

  // For LAT=0 data is captured on the enable edge; for LAT=1 one edge later.
  assign push_s = (READ_LATENCY == 0) ? fifo_read_enable : inflight_r;
  assign pop_s  = valid_r && read_ready;

  // Credit-based read request; read_ready deliberately plays no part here.
  always_comb begin
    credit_sum       = {1'b0, level_r} + {{LVL_W{1'b0}}, inflight_s};
    fifo_read_enable = 1'b0;
    if (!reset && !fifo_empty && (credit_sum < DEPTH_EXT)) begin
      fifo_read_enable = 1'b1;
    end else begin
      fifo_read_enable = 1'b0;
    end
  end

  // Next buffer occupancy from this cycle's push/pop pair.
  always_comb begin
    level_next = level_r;
    case ({push_s, pop_s})
      2'b10:   level_next = level_r + LVL_W'(1);
      2'b01:   level_next = level_r - LVL_W'(1);
      default: level_next = level_r;
    endcase
  end

  // Occupancy, valid flag, pointers and the in-flight marker.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_r    <= {LVL_W{1'b0}};
      valid_r    <= 1'b0;
      wr_ptr     <= {PTR_W{1'b0}};
      rd_ptr     <= {PTR_W{1'b0}};
      inflight_r <= 1'b0;
    end else begin
      level_r    <= level_next;
      valid_r    <= (level_next != {LVL_W{1'b0}});
      inflight_r <= (READ_LATENCY == 1) ? fifo_read_enable : 1'b0;
      if (push_s) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop_s) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
    end
  end

  // Data storage; cleared on reset so read_data reads zero afterwards.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BUFFER_DEPTH; i++) begin
        storage[i] <= {WIDTH{1'b0}};
      end
    end else if (push_s) begin
      storage[wr_ptr] <= fifo_read_data;
    end
  end

  assign read_valid = valid_r;
  assign read_data  = storage[rd_ptr];
  assign level      = level_r;

endmodule : fifo_valid_ready_reader

// File: tb/tb_fifo_valid_ready_reader.sv
// Testbench: tb_fifo_valid_ready_reader
//
// Two lanes run side by side on shared write/ready stimulus: lane 0 is a
// LAT=0 reader with BUFFER_DEPTH=2, lane 1 a LAT=1 reader with BUFFER_DEPTH=3.
// Each lane pairs the reader with a depth-4 behavioural FIFO of matching read
// latency. Every written word is appended to an expected-data queue; a
// monitor pops from it per lane whenever a handshake is seen.
module tb_fifo_valid_ready_reader;

  localparam int FD   = 4;
  localparam int NEXP = 2048;

  logic       clock   = 1'b0;
  logic       reset   = 1'b0;
  logic       wr_en   = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       ready   = 1'b0;

  logic [7:0] exp_q [NEXP];
  int         wr_idx = 0;
  int         rd_idx [2];
  int         xcyc [2][NEXP];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  logic [1:0]      rv_v;
  logic [1:0]      fre_v;
  logic [1:0][7:0] rdata_v;
  logic [1:0][3:0] lvl_v;
  logic [1:0][2:0] fcnt_v;

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = g;
    localparam int BD  = g + 2;
    localparam int LW  = $clog2(BD + 1);

    logic [7:0]    mem [FD];
    logic [1:0]    fwp;
    logic [1:0]    frp;
    logic [2:0]    fcnt;
    logic [7:0]    freg;
    logic          fempty;
    logic [7:0]    fdata;
    logic          wr_ok;
    logic          rd_ok;
    logic [LW-1:0] lvl;

    assign fempty = (fcnt == 3'd0);
    assign wr_ok  = wr_en && (fcnt != 3'd4);
    assign rd_ok  = fre_v[g] && (fcnt != 3'd0);
    assign fdata  = (LAT == 0) ? mem[frp] : freg;
    assign fcnt_v[g] = fcnt;
    assign lvl_v[g]  = 4'(lvl);

    // Behavioural read-enable FIFO, depth 4, reset in the same domain.
    always @(posedge clock or posedge reset) begin
      if (reset) begin
        fwp  <= 2'd0;
        frp  <= 2'd0;
        fcnt <= 3'd0;
        freg <= 8'h00;
      end else begin
        if (wr_ok) begin
          mem[fwp] <= wr_data;
          fwp      <= fwp + 2'd1;
        end
        if (rd_ok) begin
          freg <= mem[frp];
          frp  <= frp + 2'd1;
        end
        fcnt <= fcnt + {2'b00, wr_ok} - {2'b00, rd_ok};
      end
    end

    fifo_valid_ready_reader #(
      .WIDTH        (8),
      .READ_LATENCY (LAT),
      .BUFFER_DEPTH (BD)
    ) u_dut (
      .clock            (clock),
      .reset            (reset),
      .fifo_read_enable (fre_v[g]),
      .fifo_read_data   (fdata),
      .fifo_empty       (fempty),
      .read_valid       (rv_v[g]),
      .read_data        (rdata_v[g]),
      .read_ready       (ready),
      .level            (lvl)
    );
  end

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: pops expected data on every handshake of each lane.
  task automatic monitor();
    forever begin
      @(negedge clock);
      for (int g = 0; g < 2; g++) begin
        if (reset) begin
          rd_idx[g] = wr_idx;
        end else begin
          chk(int'(lvl_v[g]) <= g + 2, $sformatf("level_bound_l%0d", g), int'(lvl_v[g]), g + 2);
          if (fre_v[g]) begin
            chk(fcnt_v[g] != 3'd0, $sformatf("fifo_underflow_l%0d", g), int'(fcnt_v[g]), 1);
          end
          if (rv_v[g] && ready) begin
            if (rd_idx[g] >= wr_idx) begin
              chk(1'b0, $sformatf("unexpected_data_l%0d", g), int'(rdata_v[g]), 0);
            end else begin
              chk(rdata_v[g] == exp_q[rd_idx[g]], $sformatf("data_l%0d_idx%0d", g, rd_idx[g]),
                  int'(rdata_v[g]), int'(exp_q[rd_idx[g]]));
              xcyc[g][rd_idx[g]] = cyc;
              rd_idx[g]++;
            end
          end
        end
      end
    end
  endtask

  task automatic wr(input logic [7:0] d);
    int n = 0;
    while ((fcnt_v[0] == 3'd4 || fcnt_v[1] == 3'd4) && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 100) begin
      chk(1'b0, "write_full_timeout", n, 100);
    end
    wr_en = 1'b1;
    wr_data = d;
    exp_q[wr_idx] = d;
    wr_idx++;
    @(posedge clock); #1;
    wr_en = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((rd_idx[0] != wr_idx || rd_idx[1] != wr_idx) && n < 300) begin
      @(posedge clock); #1;
      n++;
    end
    chk(n < 300, name, rd_idx[0] + rd_idx[1], 2 * wr_idx);
  endtask

  initial begin
    int base;
    int c0;
    fork
      monitor();
    join_none

    // 1: reset, FIFO empty -> idle outputs for 10 cycles after release
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      for (int g = 0; g < 2; g++) begin
        chk(rv_v[g] == 1'b0, $sformatf("idle_valid_l%0d", g), int'(rv_v[g]), 0);
        chk(fre_v[g] == 1'b0, $sformatf("idle_rden_l%0d", g), int'(fre_v[g]), 0);
        chk(lvl_v[g] == 4'd0, $sformatf("idle_level_l%0d", g), int'(lvl_v[g]), 0);
      end
    end
    @(posedge clock); #1;

    // 2: four words streamed in order; latency 1+LAT from empty falling
    ready = 1'b1;
    base = wr_idx;
    wr(8'h11);
    c0 = cyc;
    wr(8'h22);
    wr(8'h33);
    wr(8'h44);
    drain("drain_basic");
    for (int g = 0; g < 2; g++) begin
      chk(xcyc[g][base] - c0 == 1 + g, $sformatf("latency_l%0d", g), xcyc[g][base] - c0, 1 + g);
    end

    // 3: backpressure fills the buffer, FIFO keeps the remainder, head stable
    ready = 1'b0;
    wr(8'hA1);
    wr(8'hA2);
    wr(8'hA3);
    wr(8'hA4);
    repeat (10) @(posedge clock);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      for (int g = 0; g < 2; g++) begin
        chk(lvl_v[g] == 4'(g + 2), $sformatf("bp_level_l%0d", g), int'(lvl_v[g]), g + 2);
        chk(fre_v[g] == 1'b0, $sformatf("bp_rden_l%0d", g), int'(fre_v[g]), 0);
        chk(fcnt_v[g] == 3'(FD - (g + 2)), $sformatf("bp_fifo_cnt_l%0d", g), int'(fcnt_v[g]), FD - (g + 2));
        chk(rdata_v[g] == 8'hA1, $sformatf("bp_head_stable_l%0d", g), int'(rdata_v[g]), 'hA1);
      end
    end
    @(posedge clock); #1;
    ready = 1'b1;
    drain("drain_backpressure");

    // 4: 100 back-to-back words, one transfer per cycle after fill
    base = wr_idx;
    for (int i = 0; i < 100; i++) wr(8'(i));
    drain("drain_stream");
    for (int g = 0; g < 2; g++) begin
      chk(xcyc[g][base + 99] - xcyc[g][base] == 99, $sformatf("throughput_l%0d", g),
          xcyc[g][base + 99] - xcyc[g][base], 99);
    end

    // 5: random writes and ready for 1000 cycles
    for (int i = 0; i < 1000; i++) begin
      ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1 && fcnt_v[0] != 3'd4 && fcnt_v[1] != 3'd4) begin
        wr_en = 1'b1;
        wr_data = 8'($urandom);
        exp_q[wr_idx] = wr_data;
        wr_idx++;
      end else begin
        wr_en = 1'b0;
      end
      @(posedge clock); #1;
    end
    wr_en = 1'b0;
    ready = 1'b1;
    drain("drain_random");

    // 6: reset with level=2 and a LAT=1 read in flight
    ready = 1'b0;
    for (int k = 0; k < 4 && lvl_v[1] != 4'd2; k++) wr(8'h5A + 8'(k));
    chk(lvl_v[1] == 4'd2, "rst_setup_level_l1", int'(lvl_v[1]), 2);
    reset = 1'b1;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk(rv_v[g] == 1'b0, $sformatf("rst_valid_l%0d", g), int'(rv_v[g]), 0);
      chk(lvl_v[g] == 4'd0, $sformatf("rst_level_l%0d", g), int'(lvl_v[g]), 0);
      chk(fre_v[g] == 1'b0, $sformatf("rst_rden_l%0d", g), int'(fre_v[g]), 0);
      chk(rdata_v[g] == 8'h00, $sformatf("rst_data_l%0d", g), int'(rdata_v[g]), 0);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    ready = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    for (int g = 0; g < 2; g++) begin
      chk(rv_v[g] == 1'b0, $sformatf("post_rst_valid_l%0d", g), int'(rv_v[g]), 0);
      chk(lvl_v[g] == 4'd0, $sformatf("post_rst_level_l%0d", g), int'(lvl_v[g]), 0);
    end
    wr(8'hA5);
    drain("drain_post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_fifo_valid_ready_reader
